// File: rtl/multdiv_sequencer_pkg.sv
// cpu_pkg: constants and types shared by the multiply/divide sequencer.
//   OP_RTYPE / ALU_MUL / ALU_DIV : decode values that select a mul/div op
//   RSTATUS_REG                  : register written when an op faults
//   MUL_EXC_CODE / DIV_EXC_CODE  : values written to RSTATUS_REG
//   state_t                      : sequencer FSM states
// No ports. No configuration macros.
package cpu_pkg;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  localparam logic [4:0]  RSTATUS_REG  = 5'd30;
  localparam int unsigned MUL_EXC_CODE = 4;
  localparam int unsigned DIV_EXC_CODE = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_multdiv(input logic [4:0] opcode, input logic [4:0] aluop);
    return (opcode == OP_RTYPE) && ((aluop == ALU_MUL) || (aluop == ALU_DIV));
  endfunction

endpackage

// File: rtl/multdiv_sequencer_if.sv
// multdiv_sequencer_if: execute-stage request and writeback bundle.
//   instr_valid, opcode, aluop, rd, operand_a, operand_b : request (pipeline -> sequencer)
//   stall, busy                                           : pipeline control (sequencer -> pipeline)
//   wb_we, wb_rd, wb_data, exception                      : register-file write port
// Modports: master = pipeline side, slave = sequencer side.
interface multdiv_sequencer_if #(
  parameter int unsigned WIDTH = 32
);

  logic             instr_valid;
  logic [4:0]       opcode;
  logic [4:0]       aluop;
  logic [4:0]       rd;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             stall;
  logic             busy;
  logic             wb_we;
  logic [4:0]       wb_rd;
  logic [WIDTH-1:0] wb_data;
  logic             exception;

  modport master (
    output instr_valid, opcode, aluop, rd, operand_a, operand_b,
    input  stall, busy, wb_we, wb_rd, wb_data, exception
  );

  modport slave (
    input  instr_valid, opcode, aluop, rd, operand_a, operand_b,
    output stall, busy, wb_we, wb_rd, wb_data, exception
  );

endinterface

// File: rtl/multdiv_iter_core.sv
// multdiv_iter_core: one-bit-per-step shift-add multiplier and restoring
// divider operating on operand magnitudes, with sign fixup on the way out.
//   clock, reset   : system clock, synchronous active-high reset
//   start          : load operands and clear accumulators
//   op_div         : 1 = divide, 0 = multiply (sampled on start)
//   step           : advance one bit
//   operand_a/b    : multiplicand/dividend, multiplier/divisor
//   result         : signed result including the bit processed this cycle
//   overflow       : result does not fit in WIDTH bits (div: MIN / -1 only)
//   mul_last       : (MULTDIV_EARLY_TERM_EN only) no multiplier bits remain
//                    after the current step
// result/overflow reflect the step being taken in the current cycle, so the
// sequencer can register them on the same edge that finishes the op.
module multdiv_iter_core
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op_div,
  input  logic             step,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic [WIDTH-1:0] result,
  output logic             overflow
`ifdef MULTDIV_EARLY_TERM_EN
  ,
  output logic             mul_last
`endif
);

  logic               op_div_q;
  logic               neg_q;
  logic               div_ovf_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   quo_q;
  logic [WIDTH-1:0]   divisor_q;

  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] prod_nx;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     diff;
  logic               take;
  logic [WIDTH-1:0]   rem_nx;
  logic [WIDTH-1:0]   quo_nx;
  logic [2*WIDTH-1:0] mul_signed;
  logic               mul_ovf;
  logic [WIDTH-1:0]   div_signed;

  assign mag_a = operand_a[WIDTH-1] ? -operand_a : operand_a;
  assign mag_b = operand_b[WIDTH-1] ? -operand_b : operand_b;

  always_ff @(posedge clock) begin
    if (reset) begin
      op_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      div_ovf_q <= 1'b0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      prod_q    <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
    end else if (start) begin
      op_div_q  <= op_div;
      neg_q     <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
      div_ovf_q <= op_div && (operand_a == {1'b1, {(WIDTH-1){1'b0}}}) && (operand_b == '1);
      mcand_q   <= {{WIDTH{1'b0}}, mag_a};
      mplier_q  <= mag_b;
      prod_q    <= '0;
      rem_q     <= '0;
      quo_q     <= mag_a;
      divisor_q <= mag_b;
    end else if (step) begin
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      prod_q   <= prod_nx;
      rem_q    <= rem_nx;
      quo_q    <= quo_nx;
    end
  end

  // Shift-add: multiplicand walks left, multiplier walks right.
  assign prod_nx = mplier_q[0] ? (prod_q + mcand_q) : prod_q;

  // Restoring divide: dividend bits shift out of quo_q into the remainder,
  // quotient bits shift in behind them. Bit WIDTH of diff is the borrow.
  assign rem_sh = {rem_q, quo_q[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, divisor_q};
  assign take   = ~diff[WIDTH];
  assign rem_nx = take ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign quo_nx = {quo_q[WIDTH-2:0], take};

  assign mul_signed = neg_q ? -prod_nx : prod_nx;
  // Fits iff the upper half plus the low-half sign bit are all equal.
  assign mul_ovf    = !((&mul_signed[2*WIDTH-1:WIDTH-1]) || !(|mul_signed[2*WIDTH-1:WIDTH-1]));
  assign div_signed = neg_q ? -quo_nx : quo_nx;

  assign result   = op_div_q ? div_signed : mul_signed[WIDTH-1:0];
  assign overflow = op_div_q ? div_ovf_q : mul_ovf;

`ifdef MULTDIV_EARLY_TERM_EN
  assign mul_last = (mplier_q >> 1) == '0;
`endif

endmodule

// File: rtl/multdiv_sequencer.sv
// multdiv_sequencer: detects MUL/DIV in execute, stalls the front of the
// pipeline while multdiv_iter_core iterates, then issues one writeback to rd
// (or to RSTATUS_REG with an exception code when the op faults).
//   clock, reset : system clock, synchronous active-high reset
//   ifc (slave)  : request in, stall/busy and registered writeback out
// Optional macro MULTDIV_EARLY_TERM_EN: multiply leaves RUN as soon as no
// multiplier bits remain; a zero multiplier completes straight from IDLE.
//
// state | meaning
// IDLE  | waiting for a mul/div; stall follows start combinationally
// RUN   | one iteration per cycle, pipeline stalled
// DONE  | single-cycle writeback, stall released
module multdiv_sequencer #(
  parameter int unsigned WIDTH        = 32,
  parameter logic [4:0]  RSTATUS_REG  = cpu_pkg::RSTATUS_REG,
  parameter int unsigned MUL_EXC_CODE = cpu_pkg::MUL_EXC_CODE,
  parameter int unsigned DIV_EXC_CODE = cpu_pkg::DIV_EXC_CODE
) (
  input logic              clock,
  input logic              reset,
  multdiv_sequencer_if.slave ifc
);

  import cpu_pkg::*;

  localparam int unsigned CNT_W = $clog2(WIDTH);

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] counter;
  logic             op_div_q;
  logic [4:0]       rd_q;

  logic             start;
  logic             is_div;
  logic             start_done;
  logic             run_done;
  logic             step;
  logic [WIDTH-1:0] core_result;
  logic             core_ovf;

  assign start  = ifc.instr_valid && is_multdiv(ifc.opcode, ifc.aluop) && (state == IDLE);
  assign is_div = ifc.aluop == ALU_DIV;
  assign step   = state == RUN;

`ifdef MULTDIV_EARLY_TERM_EN
  logic mul_last;
  // A zero divisor faults and a zero multiplier yields zero: both finish at once.
  assign start_done = ifc.operand_b == '0;
  assign run_done   = (counter == CNT_W'(WIDTH-1)) || (!op_div_q && mul_last);
`else
  assign start_done = is_div && (ifc.operand_b == '0);
  assign run_done   = counter == CNT_W'(WIDTH-1);
`endif

  multdiv_iter_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .op_div    (is_div),
    .step      (step),
    .operand_a (ifc.operand_a),
    .operand_b (ifc.operand_b),
    .result    (core_result),
    .overflow  (core_ovf)
`ifdef MULTDIV_EARLY_TERM_EN
    ,
    .mul_last  (mul_last)
`endif
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    ifc.stall = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          ifc.stall = 1'b1;
          state_nx  = start_done ? DONE : RUN;
        end
      end
      RUN: begin
        ifc.stall = 1'b1;
        if (run_done) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign ifc.busy = state != IDLE;

  always_ff @(posedge clock) begin
    if (reset) begin
      counter  <= '0;
      op_div_q <= 1'b0;
      rd_q     <= '0;
    end else if (start) begin
      counter  <= '0;
      op_div_q <= is_div;
      rd_q     <= ifc.rd;
    end else if (state == RUN) begin
      counter  <= counter + CNT_W'(1);
    end
  end

  // Writeback is loaded on the edge that enters DONE, so it is valid
  // exactly for the DONE cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      ifc.wb_we     <= 1'b0;
      ifc.wb_rd     <= '0;
      ifc.wb_data   <= '0;
      ifc.exception <= 1'b0;
    end else begin
      ifc.wb_we     <= 1'b0;
      ifc.exception <= 1'b0;
      if (start && start_done) begin
        ifc.wb_we <= 1'b1;
        if (is_div) begin
          ifc.exception <= 1'b1;
          ifc.wb_rd     <= RSTATUS_REG;
          ifc.wb_data   <= WIDTH'(DIV_EXC_CODE);
        end else begin
          ifc.wb_rd   <= ifc.rd;
          ifc.wb_data <= '0;
        end
      end else if ((state == RUN) && run_done) begin
        ifc.wb_we <= 1'b1;
        if (core_ovf) begin
          ifc.exception <= 1'b1;
          ifc.wb_rd     <= RSTATUS_REG;
          ifc.wb_data   <= op_div_q ? WIDTH'(DIV_EXC_CODE) : WIDTH'(MUL_EXC_CODE);
        end else begin
          ifc.wb_rd   <= rd_q;
          ifc.wb_data <= core_result;
        end
      end
    end
  end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Self-checking bench for multdiv_sequencer: table of directed mul/div
// vectors plus hand-written reset-abort and back-to-back sequences.
module tb_multdiv_sequencer;
  import cpu_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  multdiv_sequencer_if #(.WIDTH(32)) ifc ();

  multdiv_sequencer #(.WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .ifc   (ifc)
  );

  typedef struct {
    string       name;
    logic [4:0]  aluop;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
    logic        exp_exc;
  } vec_t;

  vec_t vecs[15];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else pass_cnt++;
  endtask

  // Expected cycles from start (T) to the writeback cycle.
  function automatic int exp_lat(input logic [4:0] aluop, input logic [31:0] b);
`ifdef MULTDIV_EARLY_TERM_EN
    logic [31:0] mag;
    int          hb;
`endif
    if (aluop == ALU_DIV) return (b == 32'd0) ? 1 : 33;
`ifdef MULTDIV_EARLY_TERM_EN
    mag = b[31] ? (32'd0 - b) : b;
    if (mag == 32'd0) return 1;
    hb = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) hb = i;
    return hb + 2;
`else
    return 33;
`endif
  endfunction

  task automatic drive(input logic [4:0] aluop, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    ifc.instr_valid = 1'b1;
    ifc.opcode      = OP_RTYPE;
    ifc.aluop       = aluop;
    ifc.rd          = rd;
    ifc.operand_a   = a;
    ifc.operand_b   = b;
  endtask

  // Called #1 after a posedge; counts cycles until wb_we, bounded.
  task automatic wait_wb(output int k, output bit stall_ok);
    bit got;
    k        = 0;
    got      = 0;
    stall_ok = 1;
    while (k < 100 && !got) begin
      @(posedge clock); #1;
      k++;
      if (ifc.wb_we) got = 1;
      else if (!ifc.stall) stall_ok = 0;
    end
  endtask

  task automatic run_op(input vec_t v);
    int k;
    bit stall_ok;
    @(negedge clock);
    drive(v.aluop, v.a, v.b, v.rd);
    #1;
    check({v.name, " stall_T"}, 32'(ifc.stall), 32'd1);
    wait_wb(k, stall_ok);
    ifc.instr_valid = 1'b0;
    check({v.name, " latency"}, 32'(k), 32'(exp_lat(v.aluop, v.b)));
    check({v.name, " stall_run"}, 32'(stall_ok), 32'd1);
    check({v.name, " stall_done"}, 32'(ifc.stall), 32'd0);
    check({v.name, " wb_rd"}, 32'(ifc.wb_rd), 32'(v.exp_rd));
    check({v.name, " wb_data"}, ifc.wb_data, v.exp_data);
    check({v.name, " exception"}, 32'(ifc.exception), 32'(v.exp_exc));
    @(posedge clock); #1;
    check({v.name, " single_pulse"}, 32'(ifc.wb_we), 32'd0);
    check({v.name, " idle_after"}, 32'(ifc.busy), 32'd0);
  endtask

  initial begin
    int k;
    int pulses;
    bit stall_ok;

    vecs[0]  = '{"mul_7_m6",      ALU_MUL, 32'd7,          32'hFFFFFFFA, 5'd3,  5'd3,  32'hFFFFFFD6, 1'b0};
    vecs[1]  = '{"mul_ovf_2p32",  ALU_MUL, 32'h00010000,   32'h00010000, 5'd7,  5'd30, 32'd4,        1'b1};
    vecs[2]  = '{"div_m7_2",      ALU_DIV, 32'hFFFFFFF9,   32'd2,        5'd5,  5'd5,  32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{"div_9_0",       ALU_DIV, 32'd9,          32'd0,        5'd8,  5'd30, 32'd5,        1'b1};
    vecs[4]  = '{"div_min_m1",    ALU_DIV, 32'h80000000,   32'hFFFFFFFF, 5'd9,  5'd30, 32'd5,        1'b1};
    vecs[5]  = '{"mul_min_1",     ALU_MUL, 32'h80000000,   32'd1,        5'd10, 5'd10, 32'h80000000, 1'b0};
    vecs[6]  = '{"mul_m1_m1_r0",  ALU_MUL, 32'hFFFFFFFF,   32'hFFFFFFFF, 5'd0,  5'd0,  32'd1,        1'b0};
    vecs[7]  = '{"div_7_m7",      ALU_DIV, 32'd7,          32'hFFFFFFF9, 5'd11, 5'd11, 32'hFFFFFFFF, 1'b0};
    vecs[8]  = '{"div_0_5",       ALU_DIV, 32'd0,          32'd5,        5'd12, 5'd12, 32'd0,        1'b0};
    vecs[9]  = '{"mul_5_1",       ALU_MUL, 32'd5,          32'd1,        5'd13, 5'd13, 32'd5,        1'b0};
    vecs[10] = '{"mul_min_min",   ALU_MUL, 32'h80000000,   32'h80000000, 5'd14, 5'd30, 32'd4,        1'b1};
    vecs[11] = '{"mul_x_0",       ALU_MUL, 32'h00012345,   32'd0,        5'd15, 5'd15, 32'd0,        1'b0};
    vecs[12] = '{"div_100_7",     ALU_DIV, 32'd100,        32'd7,        5'd16, 5'd16, 32'd14,       1'b0};
    vecs[13] = '{"mul_neg_2p31",  ALU_MUL, 32'hFFFF8000,   32'h00010000, 5'd17, 5'd17, 32'h80000000, 1'b0};
    vecs[14] = '{"mul_pos_2p31",  ALU_MUL, 32'h00008000,   32'h00010000, 5'd18, 5'd30, 32'd4,        1'b1};

    reset           = 1'b1;
    ifc.instr_valid = 1'b0;
    ifc.opcode      = '0;
    ifc.aluop       = '0;
    ifc.rd          = '0;
    ifc.operand_a   = '0;
    ifc.operand_b   = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst stall", 32'(ifc.stall), 32'd0);
    check("rst busy", 32'(ifc.busy), 32'd0);
    check("rst wb_we", 32'(ifc.wb_we), 32'd0);
    check("rst wb_rd", 32'(ifc.wb_rd), 32'd0);
    check("rst wb_data", ifc.wb_data, 32'd0);
    check("rst exception", 32'(ifc.exception), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Non-mul/div instructions must not start the sequencer.
    drive(5'b00001, 32'd3, 32'd4, 5'd1);
    #1;
    check("other_alu stall", 32'(ifc.stall), 32'd0);
    @(negedge clock);
    ifc.opcode = 5'b00001;
    ifc.aluop  = ALU_MUL;
    #1;
    check("other_op stall", 32'(ifc.stall), 32'd0);
    @(posedge clock); #1;
    check("other_op busy", 32'(ifc.busy), 32'd0);
    ifc.instr_valid = 1'b0;

    for (int i = 0; i < 15; i++) run_op(vecs[i]);

    // Reset in the middle of a multiply aborts it with no writeback.
    @(negedge clock);
    drive(ALU_MUL, 32'h1234, 32'h55, 5'd4);
    repeat (10) @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    reset           = 1'b0;
    ifc.instr_valid = 1'b0;
    #1;
    check("abort busy", 32'(ifc.busy), 32'd0);
    check("abort stall", 32'(ifc.stall), 32'd0);
    check("abort wb_we", 32'(ifc.wb_we), 32'd0);
    pulses = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (ifc.wb_we) pulses++;
    end
    check("abort no_wb", 32'(pulses), 32'd0);
    run_op('{"mul_3_4_after_abort", ALU_MUL, 32'd3, 32'd4, 5'd6, 5'd6, 32'd12, 1'b0});

    // Back-to-back: instr_valid held, next op presented in the DONE cycle.
    @(negedge clock);
    drive(ALU_MUL, 32'd2, 32'd3, 5'd1);
    wait_wb(k, stall_ok);
    check("b2b mul latency", 32'(k), 32'(exp_lat(ALU_MUL, 32'd3)));
    check("b2b mul wb_data", ifc.wb_data, 32'd6);
    check("b2b mul wb_rd", 32'(ifc.wb_rd), 32'd1);
    drive(ALU_DIV, 32'd20, 32'd4, 5'd2);
    @(posedge clock); #1;
    check("b2b second start stall", 32'(ifc.stall), 32'd1);
    check("b2b second start idle", 32'(ifc.busy), 32'd0);
    wait_wb(k, stall_ok);
    ifc.instr_valid = 1'b0;
    check("b2b div latency", 32'(k), 32'd33);
    check("b2b div wb_data", ifc.wb_data, 32'd5);
    check("b2b div wb_rd", 32'(ifc.wb_rd), 32'd2);
    check("b2b div exception", 32'(ifc.exception), 32'd0);
    @(posedge clock); #1;
    check("b2b idle_after", 32'(ifc.busy), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
